mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single-port instruction/data RAM of mips_sopc between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each RAM access over a fixed, parameterised latency, returns read data and a one-cycle ack to the winner, and raises a stall request to the pipeline controller while any access is outstanding.

Parameters:
- ADDR_W, 32, address width for both ports and the RAM.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, number of cycles ram_ce is held per access. Legal range is 1..15; the counter is 4 bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held by IF until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  load/store request; held by MEM until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  4  byte enables for the store.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; registered; valid when mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse for MEM.
- stall_req  out  1  pipeline stall request.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_sel  out  4  RAM byte enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid in the last ram_ce cycle of an access.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE and cnt=0.
  - All registered outputs go to 0: if_rdata, mem_rdata, if_ack, mem_ack, ram_ce, ram_we, ram_sel, ram_addr, ram_wdata.
- States: IDLE, ACC_IF, ACC_MEM, ACK.
- IDLE:
  - If mem_req=1, go to ACC_MEM. MEM has fixed priority: it is the older instruction.
  - Else if if_req=1, go to ACC_IF.
  - Else stay in IDLE.
  - On the transition edge, register the winner's addr, we, sel and wdata onto the ram_* outputs, set ram_ce=1, and set cnt=MEM_LATENCY-1.
  - A fetch always drives ram_we=0 and ram_sel=4'b0000.
- ACC_IF / ACC_MEM:
  - ram_* outputs are held stable.
  - While cnt≠0, decrement cnt each cycle.
  - In the cycle cnt=0:
    - On a load or fetch, capture ram_rdata into if_rdata or mem_rdata. A store leaves mem_rdata unchanged.
    - Clear ram_ce, ram_we and ram_sel; zero ram_addr and ram_wdata.
    - Assert the matching ack (registered) and go to ACK.
- ACK:
  - The ack is high for exactly this one cycle.
  - Requests are ignored in ACK; the state always returns to IDLE.
  - if_rdata and mem_rdata hold their values until overwritten by a later capture.
- Latency: request sampled in IDLE at cycle T → ram_ce high T+1..T+MEM_LATENCY → ack at T+MEM_LATENCY+1 → next grant sampled at T+MEM_LATENCY+2.
- stall_req is combinational: (if_req & ~if_ack) | (mem_req & ~mem_ack). It is low in the ack cycle, so the pipeline advances on the same edge.
- Simultaneous requests: MEM is served first and IF waits.
  - IF can starve only while MEM re-requests continuously. The pipeline cannot do this, because each MEM ack lets the pipeline advance.
- Request dropped mid-access (protocol violation): the access completes and ack still pulses; the requester discards it.
- Inputs changing mid-access have no effect, because the ram_* outputs are latched at grant.
- Reset mid-access: the access is abandoned with no ack and no data capture, and ram_ce=0 on the next cycle. A still-held request is re-granted from IDLE after reset deasserts.

Test Plan:
1. Reset: hold rst for 2 cycles with requests active → all outputs 0 and stall_req follows the reqs; no ram_ce until rst=0.
2. IF fetch alone, MEM_LATENCY=2, if_req at T, if_addr=0x00000100, ram_rdata=0x3C010001 → ram_ce=1, ram_addr=0x100, ram_we=0 at T+1..T+2; if_ack=1 and if_rdata=0x3C010001 at T+3; stall_req=1 at T..T+2 and 0 at T+3.
3. Simultaneous load 0x200 (ram_rdata=0xDEADBEEF) and fetch 0x104 at T → mem_ack at T+3 with mem_rdata=0xDEADBEEF; IF ram_ce at T+5..T+6 with ram_addr=0x104; if_ack at T+7.
4. Byte store mem_we=1, mem_sel=4'b0010, mem_addr=0x300, mem_wdata=0x0000AB00 → ram_we=1, ram_sel=0010, ram_wdata=0x0000AB00 at T+1..T+2; mem_ack at T+3; mem_rdata unchanged from its prior value.
5. Reset mid-access: assert rst in cycle T+1 of a fetch → no if_ack; ram_ce=0 from T+2; with if_req still held, deassert rst → a new access begins one cycle after release.
6. MEM_LATENCY=1 build with back-to-back fetches 0x0, 0x4 held → ram_ce 1 cycle each; acks at T+2 and T+5.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch (IF) and load/store (MEM).
// Each access holds ram_ce for MEM_LATENCY cycles, then pulses a one-cycle ack to the winner.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_req,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a requester raises req and holds it, with its address and data stable,
  // until it sees its ack; ack is a one-cycle pulse and the req may drop in that cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_IF  = 2'd1,
    ACC_MEM = 2'd2,
    ACK     = 2'd3
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                ram_ce_q, ram_ce_d;
  logic                ram_we_q, ram_we_d;
  logic [3:0]          ram_sel_q, ram_sel_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_sel_q   <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_sel_q   <= ram_sel_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_sel_d   = ram_sel_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        // MEM wins ties: it belongs to the older instruction in the pipeline.
        if (mem_req) begin
          state_d     = ACC_MEM;
          cnt_d       = CNT_INIT;
          ram_ce_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_sel_d   = mem_sel;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
        end else if (if_req) begin
          state_d     = ACC_IF;
          cnt_d       = CNT_INIT;
          ram_ce_d    = 1'b1;
          ram_we_d    = 1'b0;
          ram_sel_d   = 4'b0000;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
        end
      end
      ACC_IF, ACC_MEM: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (state_q == ACC_IF) begin
            if_rdata_d = ram_rdata;
            if_ack_d   = 1'b1;
          end else begin
            if (!ram_we_q) mem_rdata_d = ram_rdata;
            mem_ack_d = 1'b1;
          end
          ram_ce_d    = 1'b0;
          ram_we_d    = 1'b0;
          ram_sel_d   = 4'b0000;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          state_d     = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_ack      = if_ack_q;
  assign mem_ack     = mem_ack_q;
  assign ram_ce      = ram_ce_q;
  assign ram_we      = ram_we_q;
  assign ram_sel     = ram_sel_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign stall_req   = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);
  assign dbg_state_o = state_q;

endmodule
